game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
Sequencing controller for the snake datapath. Owns the game state machine (idle/run/pause/over), the step-rate timer with speed-up, the score counter and a small buffer of pending direction changes. Sits between key_control and snake_field: consumes start/pause/direction requests, drives snake_field's start/step/direction inputs, and reacts to its eat/death flags.

Parameters:
TICK_INIT, 12000000, initial step period in clk cycles (≥2)
TICK_MIN, 3000000, floor of the step period (≥2, ≤TICK_INIT)
TICK_STEP, 1000000, period decrement per speed-up
FOODS_PER_LEVEL, 4, foods eaten per speed-up
SCORE_BITS, 10, score counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_req  in  1  one-cycle pulse: (re)start game
pause_req  in  1  one-cycle pulse: toggle pause
dir_valid  in  1  one-cycle pulse: new direction request
dir_in  in  2  requested direction (0 up, 1 right, 2 down, 3 left)
field_ate  in  1  one-cycle pulse from field: food eaten this step
field_dead  in  1  level/pulse from field: collision
field_start  out  1  one-cycle pulse: reinitialise field
field_step  out  1  one-cycle pulse: advance snake one cell
field_dir  out  2  direction valid with field_step
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
score  out  SCORE_BITS  foods eaten, saturating
level  out  4  speed-ups applied, saturating at 15

Behaviour:
- Reset (async assert, sync-deasserted internally): state=IDLE, field_start=0, field_step=0, field_dir=1 (right), score=0, level=0, period=TICK_INIT, tick counter=0, queue empty. All outputs registered.
- Restart (start_req in any state, priority over all other inputs that cycle): next cycle field_start=1 for exactly one cycle, state=RUN, score=0, level=0, period=TICK_INIT, counter=0, cur_dir=1, queue flushed, food counter=0.
- RUN: counter increments each cycle; at counter==period-1 it wraps to 0 and next cycle field_step=1 with field_dir = queue head (popped) if non-empty, else cur_dir; cur_dir updated to emitted dir. First step exactly period cycles after field_start.
- RUN + pause_req → PAUSE; counter frozen, no steps, queue held. PAUSE + pause_req → RUN, counter resumes from held value. pause_req in IDLE/OVER ignored.
- field_dead sampled in RUN or PAUSE → OVER next cycle; pending step for that cycle suppressed; counter and queue frozen. field_dead in IDLE/OVER ignored.
- field_ate in RUN: score+1 (saturate at all-ones); food counter+1; on reaching FOODS_PER_LEVEL it clears, level+1 (sat 15), period = max(period-TICK_STEP, TICK_MIN). New period takes effect at next counter wrap; if counter already ≥ new period-1, wrap immediately next cycle. ate and dead same cycle: score counts, state→OVER.
- Direction queue, depth 2: dir_valid accepted only in RUN. Compare against tail (last queued) or cur_dir if empty; reject if equal or reverse (dir_in^2 == ref). Full → drop. Push and pop same cycle: pop old head, push appended; pushing into empty queue while popping: popped value is the pushed value only if accepted in an earlier cycle (same-cycle push not visible to pop).
- start_req and pause_req same cycle: restart wins. Counter width $clog2(TICK_INIT).

Optional Feature:
GAME_HISCORE_EN: adds output hiscore[SCORE_BITS-1:0], reset 0; on entry to OVER, hiscore = max(hiscore, score); survives restarts, cleared only by rst_n. Without macro: port and register absent, no other difference.

Decomposition:
- Package game_pkg: state encodings (ST_IDLE..ST_OVER), direction encodings (DIR_UP/RIGHT/DOWN/LEFT), reverse-direction function.
- One sub-module dir_queue: 2-entry FIFO with reversal/duplicate filtering, ports push/dir_in/ref_dir/pop/flush, outputs head/empty/full.

Test Plan:
- TICK_INIT=8: reset, start_req → field_start cycle 1, field_step at cycles 9,17,25 with field_dir=1; state=1.
- RUN, dir_in=3 (reverse of right) → rejected, next step dir=1; dir_in=0 then 3 → steps emit 0 then 3; third push while full dropped.
- pause_req at counter=5 → no steps for 20 cycles, state=2; pause_req → step exactly 3 cycles later (counter 5→7 wrap).
- FOODS_PER_LEVEL=4, TICK_STEP=2, TICK_MIN=4: four field_ate pulses → score=4, level=1, step spacing 6; four more → spacing 4; four more → stays 4, level=3.
- field_dead same cycle as counter wrap → no field_step, state=3; pause_req ignored; start_req → field_start, score=0.
- start_req and pause_req same cycle in RUN → restart, state=1; with GAME_HISCORE_EN, game scoring 5 then 2 → hiscore=5.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the snake game controller: game states, directions
// and the reverse-direction helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Opposite directions differ only in bit 1.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Two-entry buffer of pending direction changes. A request is dropped when it
// repeats or reverses the last queued direction (or ref_dir when empty).
module dir_queue
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] dir_in,
  input  logic [1:0] ref_dir,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] head,
  output logic       empty,
  output logic       full
);

  logic [1:0] q0, q1;
  logic [1:0] count;
  logic [1:0] cmp_dir;
  logic       accept;
  logic       pop_eff;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = q0;
  assign cmp_dir = (count == 2'd2) ? q1 : (count == 2'd1) ? q0 : ref_dir;
  assign accept  = push && !full && (dir_in != cmp_dir) && (dir_in != dir_reverse(cmp_dir));
  assign pop_eff = pop && !empty;

  // A same-cycle push into an empty queue is never what gets popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0    <= DIR_RIGHT;
      q1    <= DIR_RIGHT;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({pop_eff, accept})
        2'b11: q0 <= dir_in;
        2'b10: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) q0 <= dir_in;
          else               q1 <= dir_in;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/game_controller.sv
// Snake game sequencer: state machine, step-rate timer with speed-up, score.
// Define GAME_HISCORE_EN to add the hiscore output.
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_INIT       = 12000000,
  parameter int TICK_MIN        = 3000000,
  parameter int TICK_STEP       = 1000000,
  parameter int FOODS_PER_LEVEL = 4,
  parameter int SCORE_BITS      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_req,
  input  logic                  pause_req,
  input  logic                  dir_valid,
  input  logic [1:0]            dir_in,
  input  logic                  field_ate,
  input  logic                  field_dead,
  output logic                  field_start,
  output logic                  field_step,
  output logic [1:0]            field_dir,
  output logic [1:0]            state,
  output logic [SCORE_BITS-1:0] score,
  output logic [3:0]            level
`ifdef GAME_HISCORE_EN
  ,
  output logic [SCORE_BITS-1:0] hiscore
`endif
);

  localparam int CNT_W  = $clog2(TICK_INIT);
  localparam int PER_W  = $clog2(TICK_INIT + 1);
  localparam int FOOD_W = $clog2(FOODS_PER_LEVEL + 1);

  logic [1:0]            rst_pipe;
  logic                  rst_sync_n;
  game_state_t           st;
  logic [CNT_W-1:0]      cnt;
  logic [PER_W-1:0]      period;
  logic [PER_W-1:0]      period_m1;
  logic [FOOD_W-1:0]     food_cnt;
  logic                  running, dead_hit, active, wrap, ate_now, q_push, q_pop;
  logic [1:0]            q_head, step_dir;
  logic                  q_empty, q_full;
  logic [SCORE_BITS-1:0] score_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  function automatic logic [PER_W-1:0] next_period(input logic [PER_W-1:0] p);
    if (32'(p) >= 32'(TICK_MIN + TICK_STEP)) return PER_W'(32'(p) - 32'(TICK_STEP));
    else                                     return PER_W'(TICK_MIN);
  endfunction

  assign running   = (st == ST_RUN);
  assign dead_hit  = field_dead && (st == ST_RUN || st == ST_PAUSE);
  // The timer runs in any cycle that stays in or re-enters RUN.
  assign active    = !start_req && !dead_hit &&
                     ((running && !pause_req) || (st == ST_PAUSE && pause_req));
  assign period_m1 = period - PER_W'(1);
  assign wrap      = (PER_W'(cnt) >= period_m1);
  assign ate_now   = running && field_ate && !start_req;
  assign q_pop     = active && wrap;
  assign q_push    = dir_valid && running && !start_req && !dead_hit && !q_full;
  assign step_dir  = q_empty ? field_dir : q_head;
  assign score_inc = (&score) ? score : score + SCORE_BITS'(1);
  assign state     = st;

  dir_queue u_dir_queue (
    .clk     (clk),
    .rst_n   (rst_sync_n),
    .push    (q_push),
    .dir_in  (dir_in),
    .ref_dir (field_dir),
    .pop     (q_pop),
    .flush   (start_req),
    .head    (q_head),
    .empty   (q_empty),
    .full    (q_full)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      st          <= ST_IDLE;
      field_start <= 1'b0;
      field_step  <= 1'b0;
      field_dir   <= DIR_RIGHT;
      score       <= '0;
      level       <= 4'd0;
      period      <= PER_W'(TICK_INIT);
      cnt         <= '0;
      food_cnt    <= '0;
    end else begin
      field_start <= 1'b0;
      field_step  <= 1'b0;
      if (start_req) begin
        field_start <= 1'b1;
        st          <= ST_RUN;
        field_dir   <= DIR_RIGHT;
        score       <= '0;
        level       <= 4'd0;
        period      <= PER_W'(TICK_INIT);
        cnt         <= '0;
        food_cnt    <= '0;
      end else begin
        if (dead_hit)                         st <= ST_OVER;
        else if (running && pause_req)        st <= ST_PAUSE;
        else if (st == ST_PAUSE && pause_req) st <= ST_RUN;

        if (active) begin
          if (wrap) begin
            cnt        <= '0;
            field_step <= 1'b1;
            field_dir  <= step_dir;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A shortened period is picked up by the >= compare in wrap.
        if (ate_now) begin
          score <= score_inc;
          if (food_cnt == FOOD_W'(FOODS_PER_LEVEL - 1)) begin
            food_cnt <= '0;
            if (level != 4'hf) level <= level + 4'd1;
            period <= next_period(period);
          end else begin
            food_cnt <= food_cnt + FOOD_W'(1);
          end
        end
      end
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_BITS-1:0] score_final;
  assign score_final = ate_now ? score_inc : score;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)
      hiscore <= '0;
    else if (dead_hit && !start_req && score_final > hiscore)
      hiscore <= score_final;
  end
`endif

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: field_start/field_step events are
// queued as {cycle, start, step, dir} and compared by a negedge monitor.
module tb_game_controller;

  localparam int SB = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_req, pause_req, dir_valid, field_ate, field_dead;
  logic [1:0]    dir_in;
  logic          field_start, field_step;
  logic [1:0]    field_dir, state;
  logic [SB-1:0] score;
  logic [3:0]    level;
`ifdef GAME_HISCORE_EN
  logic [SB-1:0] hiscore;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [19:0] exp_q[$];

  game_controller #(
    .TICK_INIT(8), .TICK_MIN(4), .TICK_STEP(2), .FOODS_PER_LEVEL(4), .SCORE_BITS(SB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .pause_req(pause_req),
    .dir_valid(dir_valid), .dir_in(dir_in), .field_ate(field_ate), .field_dead(field_dead),
    .field_start(field_start), .field_step(field_step), .field_dir(field_dir),
    .state(state), .score(score), .level(level)
`ifdef GAME_HISCORE_EN
    , .hiscore(hiscore)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] ev(input int c, input logic s, input logic t, input logic [1:0] d);
    return {c[15:0], s, t, d};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [19:0] act, exp_v;
    if (rst_n && (field_start || field_step)) begin
      act = {cyc[15:0], field_start, field_step, field_dir};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d start=%0b step=%0b dir=%0d, expected none",
                 act[19:4], act[3], act[2], act[1:0]);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL field_event: got cyc=%0d start=%0b step=%0b dir=%0d, expected cyc=%0d start=%0b step=%0b dir=%0d",
                   act[19:4], act[3], act[2], act[1:0], exp_v[19:4], exp_v[3], exp_v[2], exp_v[1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    if (c > cyc) tick(c - cyc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic do_start(output int base);
    exp_q.push_back(ev(cyc + 1, 1'b1, 1'b0, 2'd1));
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    base = cyc;
  endtask

  task automatic pulse_pause();
    pause_req = 1'b1;
    tick(1);
    pause_req = 1'b0;
  endtask

  task automatic send_dir(input logic [1:0] d);
    dir_valid = 1'b1;
    dir_in    = d;
    tick(1);
    dir_valid = 1'b0;
  endtask

  task automatic push_step(input int c, input logic [1:0] d);
    exp_q.push_back(ev(c, 1'b0, 1'b1, d));
  endtask

  initial begin
    int b;
    rst_n = 1'b0; start_req = 1'b0; pause_req = 1'b0; dir_valid = 1'b0;
    dir_in = 2'd0; field_ate = 1'b0; field_dead = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("reset_state", 32'(state), 0);
    check("reset_score", 32'(score), 0);
    check("reset_level", 32'(level), 0);
    check("reset_dir", 32'(field_dir), 1);
    check("reset_start", 32'(field_start), 0);
    check("reset_step", 32'(field_step), 0);
`ifdef GAME_HISCORE_EN
    check("reset_hiscore", 32'(hiscore), 0);
`endif

    // steps every 8 cycles after field_start
    do_start(b);
    push_step(b + 8, 2'd1); push_step(b + 16, 2'd1); push_step(b + 24, 2'd1);
    wait_until(b + 25);
    check("run_state", 32'(state), 1);

    // direction filtering and full-queue drop
    do_start(b);
    push_step(b + 8, 2'd1); push_step(b + 16, 2'd0);
    push_step(b + 24, 2'd3); push_step(b + 32, 2'd3);
    wait_until(b + 1);
    send_dir(2'd3);
    wait_until(b + 9);
    send_dir(2'd0); send_dir(2'd3); send_dir(2'd2);
    wait_until(b + 33);

    // pause at counter 5, resume, step 3 cycles after resume request
    do_start(b);
    push_step(b + 29, 2'd1);
    wait_until(b + 5);
    pulse_pause();
    wait_until(b + 10);
    check("pause_state", 32'(state), 2);
    wait_until(b + 26);
    pulse_pause();
    wait_until(b + 28);
    check("resume_state", 32'(state), 1);
    wait_until(b + 30);

    // game scoring 5, dead on a wrap cycle together with the fifth food
    do_start(b);
    wait_until(b + 1);
    field_ate = 1'b1;
    tick(4);
    field_dead = 1'b1;
    tick(1);
    field_ate = 1'b0; field_dead = 1'b0;
    wait_until(b + 7);
    check("over_state_a", 32'(state), 3);
    check("over_score_a", 32'(score), 5);
    check("over_level_a", 32'(level), 1);
`ifdef GAME_HISCORE_EN
    check("hiscore_5", 32'(hiscore), 5);
`endif
    pulse_pause();
    tick(1);
    check("over_pause_ignored", 32'(state), 3);

    // game scoring 2
    do_start(b);
    wait_until(b + 1);
    field_ate = 1'b1;
    tick(2);
    field_ate = 1'b0; field_dead = 1'b1;
    tick(1);
    field_dead = 1'b0;
    wait_until(b + 5);
    check("over_state_b", 32'(state), 3);
    check("over_score_b", 32'(score), 2);
`ifdef GAME_HISCORE_EN
    check("hiscore_kept", 32'(hiscore), 5);
`endif

    // speed-up: period 8 -> 6 -> 4 -> floor 4, then dead on a wrap
    do_start(b);
    push_step(b + 6, 2'd1);  push_step(b + 12, 2'd1); push_step(b + 18, 2'd1);
    push_step(b + 22, 2'd1); push_step(b + 26, 2'd1); push_step(b + 30, 2'd1);
    wait_until(b + 1);
    field_ate = 1'b1; tick(4); field_ate = 1'b0;
    check("lvl1_score", 32'(score), 4);
    check("lvl1_level", 32'(level), 1);
    wait_until(b + 13);
    field_ate = 1'b1; tick(4); field_ate = 1'b0;
    wait_until(b + 19);
    field_ate = 1'b1; tick(4); field_ate = 1'b0;
    wait_until(b + 24);
    check("lvl3_score", 32'(score), 12);
    check("lvl3_level", 32'(level), 3);
    wait_until(b + 33);
    field_ate = 1'b1; field_dead = 1'b1;
    tick(1);
    field_ate = 1'b0; field_dead = 1'b0;
    wait_until(b + 35);
    check("dead_state", 32'(state), 3);
    check("dead_score", 32'(score), 13);
`ifdef GAME_HISCORE_EN
    check("hiscore_13", 32'(hiscore), 13);
`endif

    // restart from OVER, then start and pause together while running
    do_start(b);
    check("restart_state", 32'(state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_level", 32'(level), 0);
    wait_until(b + 2);
    exp_q.push_back(ev(cyc + 1, 1'b1, 1'b0, 2'd1));
    start_req = 1'b1; pause_req = 1'b1;
    tick(1);
    start_req = 1'b0; pause_req = 1'b0;
    check("start_over_pause", 32'(state), 1);
`ifdef GAME_HISCORE_EN
    check("hiscore_survives", 32'(hiscore), 13);
`endif
    tick(3);
    check("events_pending", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
